pilha_param: RTL and testbench
==============================

Name: pilha_param

Overview:
- Parametrised successor to the fixed recursion stack that saves the PC on calls and restores it on returns.
- Adds configurable data width and depth, an occupancy count, full/empty flags, and sticky overflow/underflow error flags.
- Adds push+pop-as-replace, so a tail call costs one cycle, plus a synchronous flush.
- Sits between the PC register (push data source) and the PC input mux (stack-top feed); driven by the control unit's push/pop strobes.

Parameters:
DATA_W, 32, width of each stored word (PC width)
DEPTH, 16, number of entries; legal range 2..256
CNT_W, derived = $clog2(DEPTH+1), width of the occupancy count (localparam, not overridable)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous active-low reset
limpa  input  1  synchronous flush; empties the stack
push  input  1  write dado onto the stack this cycle
pop  input  1  remove the top entry this cycle
limpa_erro  input  1  synchronous clear of the sticky error flags
dado  input  DATA_W  word to push (normally PC output)
topo  output  DATA_W  current top entry; 0 when empty
vazia  output  1  high when occupancy = 0
cheia  output  1  high when occupancy = DEPTH
nivel  output  CNT_W  current occupancy, 0..DEPTH
erro_ovf  output  1  sticky: a push was refused because the stack was full
erro_udf  output  1  sticky: a pop was refused because the stack was empty

Behaviour:
- Storage: array mem[0..DEPTH-1]; pointer sp = nivel. The top is mem[sp-1].
- Reset (rst=0, asynchronous, no clock needed):
  - sp=0, erro_ovf=0, erro_udf=0.
  - Array contents are not reset.
  - Resulting outputs: topo=0, vazia=1, cheia=0, nivel=0.
- Output timing:
  - topo, vazia, cheia and nivel are combinational decodes of registered state.
  - They reflect an operation in the same cycle as the clock edge that performs it (zero-cycle read latency after the edge).
  - The caller may sample topo in the cycle after asserting pop's predecessor. The PC mux uses topo before the pop edge.
- Per-edge priority, first match wins:
  1. limpa=1: sp<=0. push and pop are ignored. Error flags are untouched except by rule 6.
  2. push=1, pop=1, sp>0: mem[sp-1]<=dado; sp unchanged (replace top). No error, including when full.
  3. push=1, pop=1, sp=0: treated as a plain push, mem[0]<=dado, sp<=1. No error.
  4. push=1 alone:
     - sp<DEPTH: mem[sp]<=dado, sp<=sp+1.
     - sp=DEPTH: no write, sp unchanged, erro_ovf<=1.
  5. pop=1 alone:
     - sp>0: sp<=sp-1. The popped entry is not cleared.
     - sp=0: sp stays 0, erro_udf<=1.
  6. limpa_erro=1: clears both error flags, evaluated alongside rules 1-5.
     - An error raised in the same cycle by rule 4 or 5 wins; that flag ends up set.
- Error flags hold until limpa_erro or reset. A refused operation never corrupts contents.
- Pointer arithmetic is CNT_W bits wide and never wraps. Bounds are checked before update, so sp cannot reach DEPTH+1 or underflow to all-ones.
- Reset asserted mid-sequence:
  - Occupancy and flags drop immediately (asynchronous).
  - Stale array data is never visible, because topo is forced to 0 while vazia=1.
- With no strobes asserted, no state changes.
- Implementation:
  - Single always block for sp and flags with the asynchronous reset.
  - Separate clocked write block for the array, with no reset.
  - No latches.
  - Inference as distributed RAM or flops is acceptable.

Test Plan:
- Reset then idle 3 cycles -> nivel=0, vazia=1, cheia=0, topo=0, both errors 0.
- DEPTH=4: push 0x10,0x20,0x30,0x40 on consecutive cycles -> nivel 1,2,3,4, topo follows each value, cheia=1 after 4th. A 5th push of 0x50 -> erro_ovf=1, topo=0x40, nivel=4.
- From the full state: push+pop with dado=0x99 -> topo=0x99, nivel=4, erro_ovf unchanged. Then 4 pops -> topo sequence 0x30,0x20,0x10,0, vazia=1.
- Empty stack: pop -> erro_udf=1, nivel=0. Then push+pop with 0x7 -> nivel=1, topo=0x7. Then limpa_erro -> both flags 0.
- Push 0x1,0x2, then limpa asserted together with push 0x3 -> nivel=0, topo=0. Then limpa_erro asserted in the same cycle as an empty pop -> erro_udf=1.
- Push 0xA,0xB, then drive rst low mid-cycle between edges -> nivel=0, topo=0 immediately (before the next edge). After release, push 0xC -> nivel=1, topo=0xC.

Source files
------------

// File: rtl/pilha_param.sv
// pilha_param: parametrised PC return stack with occupancy, full/empty,
// sticky overflow/underflow flags, push+pop replace and synchronous flush.
//   clk, rst (async, active low), limpa (flush), push, pop,
//   limpa_erro (clear error flags), dado (push word) ->
//   topo (top entry, 0 when empty), vazia, cheia, nivel (occupancy),
//   erro_ovf, erro_udf (sticky refused push / refused pop)
module pilha_param #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              limpa,
  input  logic              push,
  input  logic              pop,
  input  logic              limpa_erro,
  input  logic [DATA_W-1:0] dado,
  output logic [DATA_W-1:0] topo,
  output logic              vazia,
  output logic              cheia,
  output logic [CNT_W-1:0]  nivel,
  output logic              erro_ovf,
  output logic              erro_udf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [AW-1:0]     topIdx;
  logic [AW-1:0]     wrIdx;
  logic              wrEn;
  logic              isEmpty;
  logic              isFull;

  // mutually exclusive op selects, flush first
  logic opClr;
  logic opRep;
  logic opPsh;
  logic opPop;

  assign isEmpty = (sp == '0);
  assign isFull  = (sp == CNT_W'(DEPTH));
  assign topIdx  = AW'(sp - CNT_W'(1));

  assign opClr = limpa;
  assign opRep = !limpa && push && pop;
  assign opPsh = !limpa && push && !pop;
  assign opPop = !limpa && !push && pop;

  always_comb begin
    wrEn  = 1'b0;
    wrIdx = AW'(sp);
    unique case (1'b1)
      opRep: begin
        wrEn  = 1'b1;
        wrIdx = isEmpty ? '0 : topIdx;
      end
      opPsh: begin
        wrEn  = !isFull;
        wrIdx = AW'(sp);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= '0;
      erro_ovf <= 1'b0;
      erro_udf <= 1'b0;
    end else begin
      // a same-cycle refusal below overrides this clear
      if (limpa_erro) begin
        erro_ovf <= 1'b0;
        erro_udf <= 1'b0;
      end
      unique case (1'b1)
        opClr: sp <= '0;
        opRep: begin
          if (isEmpty) sp <= CNT_W'(1);
        end
        opPsh: begin
          if (isFull) erro_ovf <= 1'b1;
          else        sp <= sp + CNT_W'(1);
        end
        opPop: begin
          if (isEmpty) erro_udf <= 1'b1;
          else         sp <= sp - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= dado;
  end

  // stale array data stays hidden while empty
  assign topo  = isEmpty ? '0 : mem[topIdx];
  assign vazia = isEmpty;
  assign cheia = isFull;
  assign nivel = sp;

endmodule

// File: tb/tb_pilha_param.sv
// tb_pilha_param: directed plan plus random strobes against
// a queue-based reference model of the stack.
module tb_pilha_param;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          limpa = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          limpa_erro = 1'b0;
  logic [DW-1:0] dado = '0;
  logic [DW-1:0] topo;
  logic          vazia;
  logic          cheia;
  logic [CW-1:0] nivel;
  logic          erro_ovf;
  logic          erro_udf;

  int checks = 0;
  int failures = 0;

  int mq[$];
  bit mOvf = 1'b0;
  bit mUdf = 1'b0;

  pilha_param #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk),
    .rst(rst),
    .limpa(limpa),
    .push(push),
    .pop(pop),
    .limpa_erro(limpa_erro),
    .dado(dado),
    .topo(topo),
    .vazia(vazia),
    .cheia(cheia),
    .nivel(nivel),
    .erro_ovf(erro_ovf),
    .erro_udf(erro_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    int t;
    t = (mq.size() > 0) ? mq[$] : 0;
    chk({tag, ".nivel"}, 32'(nivel), 32'(mq.size()));
    chk({tag, ".topo"}, 32'(topo), 32'(t));
    chk({tag, ".vazia"}, 32'(vazia), 32'(mq.size() == 0));
    chk({tag, ".cheia"}, 32'(cheia), 32'(mq.size() == DP));
    chk({tag, ".ovf"}, 32'(erro_ovf), 32'(mOvf));
    chk({tag, ".udf"}, 32'(erro_udf), 32'(mUdf));
  endtask

  task automatic model(input bit l, input bit pu, input bit po,
                       input bit le, input int d);
    bit nOvf;
    bit nUdf;
    nOvf = le ? 1'b0 : mOvf;
    nUdf = le ? 1'b0 : mUdf;
    if (l) mq.delete();
    else if (pu && po) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else mq.push_back(d);
    end else if (pu) begin
      if (mq.size() == DP) nOvf = 1'b1;
      else mq.push_back(d);
    end else if (po) begin
      if (mq.size() == 0) nUdf = 1'b1;
      else void'(mq.pop_back());
    end
    mOvf = nOvf;
    mUdf = nUdf;
  endtask

  // called at negedge; drives, clocks, checks 1 after edge
  task automatic cyc(input string tag, input bit l, input bit pu,
                     input bit po, input bit le, input int d);
    limpa = l;
    push = pu;
    pop = po;
    limpa_erro = le;
    dado = DW'(d);
    @(posedge clk);
    model(l, pu, po, le, d);
    #1;
    checkAll(tag);
    @(negedge clk);
    limpa = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    limpa_erro = 1'b0;
  endtask

  initial begin
    int r;
    bit l, pu, po, le;
    @(negedge clk);
    #1;
    checkAll("rst");
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 0, 0, 0);

    cyc("psh10", 0, 1, 0, 0, 'h10);
    cyc("psh20", 0, 1, 0, 0, 'h20);
    cyc("psh30", 0, 1, 0, 0, 'h30);
    cyc("psh40", 0, 1, 0, 0, 'h40);
    cyc("ovf50", 0, 1, 0, 0, 'h50);
    chk("ovfTopo", 32'(topo), 32'h40);
    cyc("rep99", 0, 1, 1, 0, 'h99);
    chk("repTopo", 32'(topo), 32'h99);
    for (int i = 0; i < 4; i++) cyc("pop", 0, 0, 1, 0, 0);
    cyc("udf", 0, 0, 1, 0, 0);
    cyc("rep7", 0, 1, 1, 0, 'h7);
    chk("rep7Topo", 32'(topo), 32'h7);
    cyc("lerr", 0, 0, 0, 1, 0);
    cyc("psh1", 0, 1, 0, 0, 'h1);
    cyc("psh2", 0, 1, 0, 0, 'h2);
    cyc("limpa", 1, 1, 0, 0, 'h3);
    cyc("lerrUdf", 0, 0, 1, 1, 0);
    chk("lerrUdfWin", 32'(erro_udf), 32'h1);
    cyc("lerr2", 0, 0, 0, 1, 0);
    cyc("pshA", 0, 1, 0, 0, 'hA);
    cyc("pshB", 0, 1, 0, 0, 'hB);
    #2;
    rst = 1'b0;
    mq.delete();
    mOvf = 1'b0;
    mUdf = 1'b0;
    #1;
    checkAll("midRst");
    @(negedge clk);
    rst = 1'b1;
    cyc("pshC", 0, 1, 0, 0, 'hC);
    chk("pshCTopo", 32'(topo), 32'hC);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      l = (r < 3);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      le = ($urandom_range(0, 99) < 6);
      cyc("rnd", l, pu, po, le, int'($urandom & 32'hFFFF));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
